// File: rtl/flags_unit_if.sv
// rtl/flags_unit_if.sv - ALU-to-flags operation bus with flag register outputs
//
// Purpose:
//   Groups the operation handshake, the ALU side-band values the flags unit
//   needs, the stall input and the architectural flag outputs into a single
//   bundle.
//
// Signals:
//   in_valid      ALU operation offered
//   in_ready      flags unit can accept this cycle
//   op            3'b000 ADD, 001 SUB/CMP, 010 ADC, 011 SBC, 100 LOGIC,
//                 101 SHIFT, 110 MSR, 111 reserved
//   set_flags     instruction updates flags (S bit)
//   a, b          ALU operands (b is post-shift)
//   result        ALU result
//   adder_cout    adder carry out (1 = no borrow for SUB/SBC)
//   shift_cout    shifter carry out
//   shift_cvalid  shifter produced a carry (nonzero shift amount)
//   msr_flags     direct flag value for MSR, [Z,C,N,V]
//   hold          pipeline stall, freezes the captured operation
//   flags         architectural flags [Z,C,N,V]
//   flags_pending a flag-writing operation is captured but not committed
//   update_pulse  one-cycle pulse the cycle after the flags change
//
// Modports:
//   master  ALU / pipeline side
//   slave   flags unit side

interface flags_unit_if #(
  parameter int WIDTH = 32
);

  logic             in_valid;
  logic             in_ready;
  logic [2:0]       op;
  logic             set_flags;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [WIDTH-1:0] result;
  logic             adder_cout;
  logic             shift_cout;
  logic             shift_cvalid;
  logic [3:0]       msr_flags;
  logic             hold;
  logic [3:0]       flags;
  logic             flags_pending;
  logic             update_pulse;

  modport master (
    output in_valid,
    output op,
    output set_flags,
    output a,
    output b,
    output result,
    output adder_cout,
    output shift_cout,
    output shift_cvalid,
    output msr_flags,
    output hold,
    input  in_ready,
    input  flags,
    input  flags_pending,
    input  update_pulse
  );

  modport slave (
    input  in_valid,
    input  op,
    input  set_flags,
    input  a,
    input  b,
    input  result,
    input  adder_cout,
    input  shift_cout,
    input  shift_cvalid,
    input  msr_flags,
    input  hold,
    output in_ready,
    output flags,
    output flags_pending,
    output update_pulse
  );

endinterface

// File: rtl/flags_unit.sv
// rtl/flags_unit.sv - condition flag producer and architectural flags register
//
// Purpose:
//   Captures one ALU operation per cycle in a single-entry stage and, on the
//   following edge (unless stalled by hold), commits the derived N, Z, C, V
//   values into the architectural flags register. The branch condition
//   checker reads that register and uses flags_pending to avoid evaluating
//   stale flags.
//
// Ports:
//   clk    clock, all logic on the rising edge
//   rst_n  synchronous active-low reset
//   bus    flags_unit_if.slave: operation handshake, ALU side-band values,
//          hold stall input, flags / flags_pending / update_pulse outputs
//
// Flag vector layout everywhere is [3]=Z, [2]=C, [1]=N, [0]=V.

module flags_unit #(
  parameter int WIDTH = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  flags_unit_if.slave  bus
);

  localparam logic [2:0] OP_ADD   = 3'b000;
  localparam logic [2:0] OP_SUB   = 3'b001;
  localparam logic [2:0] OP_ADC   = 3'b010;
  localparam logic [2:0] OP_SBC   = 3'b011;
  localparam logic [2:0] OP_LOGIC = 3'b100;
  localparam logic [2:0] OP_SHIFT = 3'b101;
  localparam logic [2:0] OP_MSR   = 3'b110;

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } stage_state_t;

  stage_state_t state, state_next;

  // Captured operation fields. Only the operand sign bits are needed for
  // overflow, so the rest of a and b is never stored.
  logic [2:0]       s1_op;
  logic             s1_set_flags;
  logic             s1_a_sign;
  logic             s1_b_sign;
  logic [WIDTH-1:0] s1_result;
  logic             s1_adder_cout;
  logic             s1_shift_cout;
  logic             s1_shift_cvalid;
  logic [3:0]       s1_msr_flags;

  logic [3:0]       flags_q;
  logic             update_pulse_q;

  logic             s1_valid;
  logic             in_ready;
  logic             accept;
  logic             load;
  logic             commit;
  logic             write_en;
  logic             flag_change;
  logic [3:0]       flags_new;

  logic             z_new;
  logic             n_new;
  logic             v_add;
  logic             v_sub;
  logic             res_sign;

  logic             unused_operand_bits;

  assign unused_operand_bits = ^{bus.a[WIDTH-2:0], bus.b[WIDTH-2:0]};

  assign s1_valid = (state == ST_FULL);

  // Ready is a pure function of stage state, hold and reset so the producer
  // can decide to offer without a combinational loop through in_valid.
  assign in_ready = rst_n && (!s1_valid || !bus.hold);
  assign accept   = bus.in_valid && in_ready;

  // ------------------------------------------------------------------
  // Stage control: EMPTY/FULL with commit on every unstalled FULL cycle.
  // ------------------------------------------------------------------
  always_comb begin
    state_next = state;
    load       = 1'b0;
    commit     = 1'b0;
    case (state)
      ST_EMPTY: begin
        // hold does not block capture into an empty stage; the op is simply
        // parked in FULL until the stall clears.
        if (accept) begin
          state_next = ST_FULL;
          load       = 1'b1;
        end
      end
      ST_FULL: begin
        if (!bus.hold) begin
          commit = 1'b1;
          if (accept) begin
            state_next = ST_FULL;
            load       = 1'b1;
          end else begin
            state_next = ST_EMPTY;
          end
        end
      end
      default: begin
        state_next = ST_EMPTY;
      end
    endcase
  end

  // ------------------------------------------------------------------
  // Flag derivation from the captured operation.
  // ------------------------------------------------------------------
  assign res_sign = s1_result[WIDTH-1];
  assign z_new    = (s1_result == '0);
  assign n_new    = res_sign;
  assign v_add    = (s1_a_sign == s1_b_sign) && (res_sign != s1_a_sign);
  assign v_sub    = (s1_a_sign != s1_b_sign) && (res_sign != s1_a_sign);

  // MSR always writes; the reserved op never does even with set_flags.
  assign write_en = (s1_set_flags && (s1_op <= OP_SHIFT)) || (s1_op == OP_MSR);

  always_comb begin
    flags_new = flags_q;
    case (s1_op)
      OP_ADD, OP_ADC: flags_new = {z_new, s1_adder_cout, n_new, v_add};
      OP_SUB, OP_SBC: flags_new = {z_new, s1_adder_cout, n_new, v_sub};
      OP_LOGIC:       flags_new = {z_new, flags_q[2], n_new, flags_q[0]};
      OP_SHIFT:       flags_new = {z_new,
                                   s1_shift_cvalid ? s1_shift_cout : flags_q[2],
                                   n_new, flags_q[0]};
      OP_MSR:         flags_new = s1_msr_flags;
      default:        flags_new = flags_q;
    endcase
  end

  // An MSR pulses even when it rewrites the same value, since software
  // asked for an explicit flag write.
  assign flag_change = commit && write_en &&
                       ((flags_new != flags_q) || (s1_op == OP_MSR));

  // ------------------------------------------------------------------
  // Registers. Reset takes priority over a commit on the same edge, so a
  // captured op is dropped with no partial flag write.
  // ------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state           <= ST_EMPTY;
      flags_q         <= 4'b0000;
      update_pulse_q  <= 1'b0;
      s1_op           <= 3'b000;
      s1_set_flags    <= 1'b0;
      s1_a_sign       <= 1'b0;
      s1_b_sign       <= 1'b0;
      s1_result       <= '0;
      s1_adder_cout   <= 1'b0;
      s1_shift_cout   <= 1'b0;
      s1_shift_cvalid <= 1'b0;
      s1_msr_flags    <= 4'b0000;
    end else begin
      state          <= state_next;
      update_pulse_q <= flag_change;
      if (commit && write_en) begin
        flags_q <= flags_new;
      end
      if (load) begin
        s1_op           <= bus.op;
        s1_set_flags    <= bus.set_flags;
        s1_a_sign       <= bus.a[WIDTH-1];
        s1_b_sign       <= bus.b[WIDTH-1];
        s1_result       <= bus.result;
        s1_adder_cout   <= bus.adder_cout;
        s1_shift_cout   <= bus.shift_cout;
        s1_shift_cvalid <= bus.shift_cvalid;
        s1_msr_flags    <= bus.msr_flags;
      end
    end
  end

  // ------------------------------------------------------------------
  // Outputs
  // ------------------------------------------------------------------
  assign bus.in_ready      = in_ready;
  assign bus.flags         = flags_q;
  assign bus.update_pulse  = update_pulse_q;
  assign bus.flags_pending = rst_n && s1_valid && (s1_set_flags || (s1_op == OP_MSR));

endmodule

// File: tb/tb_flags_unit.sv
// tb/tb_flags_unit.sv - directed self-checking bench for flags_unit

module tb_flags_unit;

  logic clk;
  logic rst_n;
  int   checks;
  int   failures;

  flags_unit_if #(.WIDTH(32)) bus ();

  flags_unit #(.WIDTH(32)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [2:0] op, input logic s, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] r, input logic ac,
                       input logic sc, input logic scv, input logic [3:0] msr);
    bus.op           = op;
    bus.set_flags    = s;
    bus.a            = a;
    bus.b            = b;
    bus.result       = r;
    bus.adder_cout   = ac;
    bus.shift_cout   = sc;
    bus.shift_cvalid = scv;
    bus.msr_flags    = msr;
    bus.in_valid     = 1'b1;
  endtask

  // Offer one op into an empty, unstalled stage and let it commit.
  task automatic send(input logic [2:0] op, input logic s, input logic [31:0] a,
                      input logic [31:0] b, input logic [31:0] r, input logic ac,
                      input logic sc, input logic scv, input logic [3:0] msr);
    drive(op, s, a, b, r, ac, sc, scv, msr);
    step();
    bus.in_valid = 1'b0;
    step();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    step();
    step();
    checks++;
    if (bus.flags !== 4'b0000) begin
      failures++;
      $display("FAIL reset_flags got=%b want=%b", bus.flags, 4'b0000);
    end
    checks++;
    if (bus.in_ready !== 1'b0) begin
      failures++;
      $display("FAIL reset_in_ready got=%b want=0", bus.in_ready);
    end
    checks++;
    if (bus.flags_pending !== 1'b0 || bus.update_pulse !== 1'b0) begin
      failures++;
      $display("FAIL reset_pending_pulse got=%b%b want=00", bus.flags_pending, bus.update_pulse);
    end
    rst_n = 1'b1;
    #1;
    checks++;
    if (bus.in_ready !== 1'b1) begin
      failures++;
      $display("FAIL release_in_ready got=%b want=1", bus.in_ready);
    end
  endtask

  task automatic test_add_overflow();
    drive(3'b000, 1'b1, 32'h7FFF_FFFF, 32'h0000_0001, 32'h8000_0000, 1'b0, 1'b0, 1'b0, 4'b0000);
    step();
    bus.in_valid = 1'b0;
    checks++;
    if (bus.flags_pending !== 1'b1 || bus.flags !== 4'b0000) begin
      failures++;
      $display("FAIL add_capture pending=%b flags=%b want pending=1 flags=0000", bus.flags_pending, bus.flags);
    end
    step();
    checks++;
    if (bus.flags !== 4'b0011) begin
      failures++;
      $display("FAIL add_flags got=%b want=%b", bus.flags, 4'b0011);
    end
    checks++;
    if (bus.update_pulse !== 1'b1 || bus.flags_pending !== 1'b0) begin
      failures++;
      $display("FAIL add_pulse pulse=%b pending=%b want pulse=1 pending=0", bus.update_pulse, bus.flags_pending);
    end
    step();
    checks++;
    if (bus.update_pulse !== 1'b0) begin
      failures++;
      $display("FAIL add_pulse_width got=%b want=0", bus.update_pulse);
    end
  endtask

  task automatic test_sub();
    send(3'b001, 1'b1, 32'd5, 32'd5, 32'd0, 1'b1, 1'b0, 1'b0, 4'b0000);
    checks++;
    if (bus.flags !== 4'b1100) begin
      failures++;
      $display("FAIL sub_equal got=%b want=%b", bus.flags, 4'b1100);
    end
    send(3'b001, 1'b1, 32'd3, 32'd5, 32'hFFFF_FFFE, 1'b0, 1'b0, 1'b0, 4'b0000);
    checks++;
    if (bus.flags !== 4'b0010) begin
      failures++;
      $display("FAIL sub_borrow got=%b want=%b", bus.flags, 4'b0010);
    end
  endtask

  task automatic test_logic_shift();
    send(3'b000, 1'b1, 32'h7FFF_FFFF, 32'h0000_0001, 32'h8000_0000, 1'b0, 1'b0, 1'b0, 4'b0000);
    checks++;
    if (bus.flags !== 4'b0011) begin
      failures++;
      $display("FAIL logic_setup got=%b want=%b", bus.flags, 4'b0011);
    end
    send(3'b100, 1'b1, 32'h1234_5678, 32'h0, 32'h0, 1'b1, 1'b1, 1'b1, 4'b0000);
    checks++;
    if (bus.flags !== 4'b1001) begin
      failures++;
      $display("FAIL logic_keep_cv got=%b want=%b", bus.flags, 4'b1001);
    end
    send(3'b101, 1'b1, 32'h0, 32'h0, 32'h1, 1'b1, 1'b1, 1'b0, 4'b0000);
    checks++;
    if (bus.flags !== 4'b0001) begin
      failures++;
      $display("FAIL shift_no_cvalid got=%b want=%b", bus.flags, 4'b0001);
    end
    send(3'b101, 1'b1, 32'h0, 32'h0, 32'h1, 1'b0, 1'b1, 1'b1, 4'b0000);
    checks++;
    if (bus.flags !== 4'b0101) begin
      failures++;
      $display("FAIL shift_cvalid got=%b want=%b", bus.flags, 4'b0101);
    end
  endtask

  task automatic test_back_to_back();
    // flags start at 0101; first op ADD 1+1=2 -> 0000, second SUB
    // 0x80000000-1 = 0x7FFFFFFF no borrow, signed overflow -> 0101.
    bus.hold = 1'b1;
    drive(3'b000, 1'b1, 32'd1, 32'd1, 32'd2, 1'b0, 1'b0, 1'b0, 4'b0000);
    step();
    drive(3'b001, 1'b1, 32'h8000_0000, 32'd1, 32'h7FFF_FFFF, 1'b1, 1'b0, 1'b0, 4'b0000);
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (bus.flags !== 4'b0101 || bus.flags_pending !== 1'b1 || bus.in_ready !== 1'b0) begin
        failures++;
        $display("FAIL hold_cycle%0d flags=%b pending=%b ready=%b want 0101/1/0",
                 i, bus.flags, bus.flags_pending, bus.in_ready);
      end
      step();
    end
    bus.hold = 1'b0;
    #1;
    checks++;
    if (bus.in_ready !== 1'b1) begin
      failures++;
      $display("FAIL hold_release_ready got=%b want=1", bus.in_ready);
    end
    step();
    bus.in_valid = 1'b0;
    checks++;
    if (bus.flags !== 4'b0000 || bus.flags_pending !== 1'b1 || bus.update_pulse !== 1'b1) begin
      failures++;
      $display("FAIL b2b_first flags=%b pending=%b pulse=%b want 0000/1/1",
               bus.flags, bus.flags_pending, bus.update_pulse);
    end
    step();
    checks++;
    if (bus.flags !== 4'b0101 || bus.flags_pending !== 1'b0 || bus.update_pulse !== 1'b1) begin
      failures++;
      $display("FAIL b2b_second flags=%b pending=%b pulse=%b want 0101/0/1",
               bus.flags, bus.flags_pending, bus.update_pulse);
    end
  endtask

  task automatic test_no_set();
    drive(3'b000, 1'b0, 32'd2, 32'd3, 32'd5, 1'b1, 1'b0, 1'b0, 4'b0000);
    step();
    bus.in_valid = 1'b0;
    checks++;
    if (bus.flags_pending !== 1'b0) begin
      failures++;
      $display("FAIL noset_pending got=%b want=0", bus.flags_pending);
    end
    step();
    checks++;
    if (bus.flags !== 4'b0101 || bus.update_pulse !== 1'b0) begin
      failures++;
      $display("FAIL noset_flags flags=%b pulse=%b want 0101/0", bus.flags, bus.update_pulse);
    end
    send(3'b111, 1'b1, 32'd0, 32'd0, 32'd0, 1'b1, 1'b1, 1'b1, 4'b1111);
    checks++;
    if (bus.flags !== 4'b0101 || bus.update_pulse !== 1'b0) begin
      failures++;
      $display("FAIL reserved_op flags=%b pulse=%b want 0101/0", bus.flags, bus.update_pulse);
    end
    drive(3'b110, 1'b0, 32'd0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0, 4'b1010);
    step();
    bus.in_valid = 1'b0;
    checks++;
    if (bus.flags_pending !== 1'b1) begin
      failures++;
      $display("FAIL msr_pending got=%b want=1", bus.flags_pending);
    end
    step();
    checks++;
    if (bus.flags !== 4'b1010 || bus.update_pulse !== 1'b1) begin
      failures++;
      $display("FAIL msr_flags flags=%b pulse=%b want 1010/1", bus.flags, bus.update_pulse);
    end
  endtask

  task automatic test_reset_mid_op();
    drive(3'b110, 1'b0, 32'd0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0, 4'b1111);
    step();
    bus.in_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    checks++;
    if (bus.in_ready !== 1'b0 || bus.flags_pending !== 1'b0) begin
      failures++;
      $display("FAIL rst_low_outputs ready=%b pending=%b want 0/0", bus.in_ready, bus.flags_pending);
    end
    step();
    checks++;
    if (bus.flags !== 4'b0000 || bus.update_pulse !== 1'b0) begin
      failures++;
      $display("FAIL rst_wins flags=%b pulse=%b want 0000/0", bus.flags, bus.update_pulse);
    end
    rst_n = 1'b1;
    #1;
    checks++;
    if (bus.in_ready !== 1'b1 || bus.flags_pending !== 1'b0) begin
      failures++;
      $display("FAIL rst_release ready=%b pending=%b want 1/0", bus.in_ready, bus.flags_pending);
    end
    step();
    checks++;
    if (bus.flags !== 4'b0000 || bus.update_pulse !== 1'b0) begin
      failures++;
      $display("FAIL rst_no_late_commit flags=%b pulse=%b want 0000/0", bus.flags, bus.update_pulse);
    end
  endtask

  initial begin
    checks           = 0;
    failures         = 0;
    rst_n            = 1'b0;
    bus.in_valid     = 1'b0;
    bus.op           = 3'b000;
    bus.set_flags    = 1'b0;
    bus.a            = '0;
    bus.b            = '0;
    bus.result       = '0;
    bus.adder_cout   = 1'b0;
    bus.shift_cout   = 1'b0;
    bus.shift_cvalid = 1'b0;
    bus.msr_flags    = 4'b0000;
    bus.hold         = 1'b0;

    test_reset();
    test_add_overflow();
    test_sub();
    test_logic_shift();
    test_back_to_back();
    test_no_set();
    test_reset_mid_op();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/flags_unit.md
Name: flags_unit

Overview:
- Producer side of the condition-flag interface: computes N, Z, C and V from each ALU operation and holds the architectural flags register.
- The branch condition checker consumes that register.
- Sits after the ALU: captures the operation in a one-entry stage, then commits new flags on the next edge.
- Exposes a pending indication so the consumer never evaluates stale flags.

Parameters:
WIDTH, 32, datapath width of operands and result

Ports:
clk  in  1  clock, all logic on rising edge
rst_n  in  1  synchronous active-low reset
in_valid  in  1  ALU operation offered
in_ready  out  1  block can accept; transfer on in_valid && in_ready at rising edge
op  in  3  000 ADD, 001 SUB/CMP, 010 ADC, 011 SBC, 100 LOGIC, 101 SHIFT, 110 MSR, 111 reserved
set_flags  in  1  instruction updates flags (S bit)
a  in  WIDTH  first ALU operand
b  in  WIDTH  second ALU operand (post-shift)
result  in  WIDTH  ALU result
adder_cout  in  1  adder carry out (ARM convention: 1 = no borrow for SUB/SBC)
shift_cout  in  1  shifter carry out
shift_cvalid  in  1  shifter produced a carry (shift amount nonzero)
msr_flags  in  4  direct flag value for MSR, [Z,C,N,V]
hold  in  1  pipeline stall; freezes the stage
flags  out  4  architectural flags [Z,C,N,V] (Zero, Carry, Negative, Overflow)
flags_pending  out  1  a flag-writing operation is captured but not yet committed
update_pulse  out  1  one-cycle pulse, high the cycle after flags change

Behaviour:
- Stage state machine, 2 states: EMPTY (s1_valid=0) and FULL (s1_valid=1). Captured fields: op, set_flags, a/b sign bits, result, couts, shift_cvalid, msr_flags.
- in_ready = rst_n && (!s1_valid || !hold). It is combinational and must not depend on in_valid.
- EMPTY: accept -> FULL. No accept -> stay EMPTY.
- FULL with hold=1: all captured fields frozen; flags unchanged.
- FULL with hold=0: commit at this edge. Next state is FULL if a new op is accepted on the same edge (back-to-back, 1 op/cycle), else EMPTY.
- Latency: op accepted at edge E0 -> flags updated at E1 (if hold=0 during the cycle before E1) -> visible the cycle after E1.
- Commit writes flags only if (set_flags && op in 000..101) or op==110. Op 111, or set_flags=0, commits with no change.
- Per-op flag rules; s = bit WIDTH-1:
  - All arithmetic/LOGIC/SHIFT: N = result[s]; Z = (result == 0).
  - ADD, ADC: C = adder_cout; V = (a[s]==b[s]) && (result[s]!=a[s]).
  - SUB, SBC: C = adder_cout; V = (a[s]!=b[s]) && (result[s]!=a[s]).
  - LOGIC: C and V unchanged.
  - SHIFT: C = shift_cout if shift_cvalid, else unchanged; V unchanged.
  - MSR: flags = msr_flags (all four bits, ignores set_flags).
- flags_pending = s1_valid && (captured set_flags || captured op==110). It is combinational from stage registers; it stays high while held.
- update_pulse: registered; 1 the cycle after a commit that changed at least one bit or was an MSR write; 0 otherwise.
- Reset (rst_n=0 at edge): flags=4'b0000, s1_valid=0, update_pulse=0. in_ready=0 and flags_pending=0 while rst_n=0.
- Reset mid-operation drops the captured op; no partial flag write.
- Simultaneous reset and commit: reset wins.
- hold while EMPTY: in_ready stays 1; the op is captured and then held in FULL.

Test Plan:
- Reset, then ADD a=0x7FFFFFFF b=0x00000001 result=0x80000000 adder_cout=0 set_flags=1 -> flags=4'b0011 one cycle after commit edge; update_pulse=1 for exactly one cycle; flags_pending=1 only during the capture cycle.
- SUB a=5 b=5 result=0 adder_cout=1 set_flags=1 -> flags=4'b1100. Next, SUB a=3 b=5 result=0xFFFFFFFE adder_cout=0 -> flags=4'b0010.
- From flags=4'b0011, LOGIC result=0 set_flags=1 -> flags=4'b1001 (C, V kept). SHIFT result=0x1 shift_cout=1 shift_cvalid=0 -> flags=4'b0001.
- Accept ADD with hold=1 for 3 cycles -> flags unchanged, flags_pending=1, in_ready=0. Second op waits on in_valid. hold drops -> first commits, second accepted same edge, second commits next edge (back-to-back).
- ADD set_flags=0 with a non-zero result -> flags unchanged, update_pulse=0, flags_pending=0. MSR msr_flags=4'b1010 set_flags=0 -> flags=4'b1010.
- Accept MSR 4'b1111 and assert rst_n=0 on the commit edge -> flags=4'b0000, update_pulse=0, s1 empty. After release, in_ready=1 the first cycle.
